// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: control inputs, instruction BRAM port and the output stream.
// The fetch unit takes the master side. The slave side is the core plus the BRAM.
interface inst_fetch_if #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INST_WIDTH = 32
);
  logic                  work_ena;
  logic                  pc_jump;
  logic [PC_WIDTH-1:0]   pc_target;
  logic                  imem_en;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [INST_WIDTH-1:0] out_inst;

  modport master (
    input  work_ena, pc_jump, pc_target, imem_rdata, out_ready,
    output imem_en, imem_addr, out_valid, out_pc, out_inst
  );

  modport slave (
    output work_ena, pc_jump, pc_target, imem_rdata, out_ready,
    input  imem_en, imem_addr, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: sequential PC with redirect, one-cycle BRAM read,
// 2-entry {pc, inst} output FIFO throttled so no BRAM response is ever lost.
module inst_fetch #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(4)
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_fetch_if.master  bus
);

  logic [PC_WIDTH-1:0]   fetch_pc;
  logic [PC_WIDTH-1:0]   infl_pc;
  logic                  inflight;
  logic [PC_WIDTH-1:0]   fifo_pc   [2];
  logic [INST_WIDTH-1:0] fifo_inst [2];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic [1:0]            count;

  logic                  pop;
  logic                  push;
  logic                  drop;
  logic                  issue;
  logic [2:0]            occupancy;

  always_comb begin
    pop       = (count != 2'd0) && bus.out_ready;
    // A response that lands in a flush cycle is discarded. Nothing issues
    // in that cycle, so no later response needs to be dropped.
    drop      = !bus.work_ena || bus.pc_jump;
    push      = inflight && !drop;
    occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue     = rst_n && bus.work_ena && !bus.pc_jump && (occupancy < 3'd2);

    bus.imem_en   = issue;
    bus.imem_addr = fetch_pc;
    bus.out_valid = (count != 2'd0);
    bus.out_pc    = fifo_pc[rd_ptr];
    bus.out_inst  = fifo_inst[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      infl_pc  <= '0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        infl_pc  <= fetch_pc;
        fetch_pc <= fetch_pc + PC_INC;
      end else if (!bus.work_ena) begin
        fetch_pc <= RESET_PC;
      end else if (bus.pc_jump) begin
        fetch_pc <= bus.pc_target;
      end

      if (drop) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]   <= infl_pc;
          fifo_inst[wr_ptr] <= bus.imem_rdata;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch. Expected {pc, inst} pairs are queued at issue
// time, and negedge monitors pop and compare them on every accepted output.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_n2;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] q_pc[$], q_inst[$], q2_pc[$], q2_inst[$];
  logic [31:0] e_pc, e_inst, e2_pc, e2_inst;

  inst_fetch_if #(.PC_WIDTH(32), .INST_WIDTH(32)) ifc ();
  inst_fetch_if #(.PC_WIDTH(8),  .INST_WIDTH(32)) ifc2 ();

  inst_fetch #(.PC_WIDTH(32), .INST_WIDTH(32), .RESET_PC(32'h0), .PC_INC(32'd4))
    dut (.clk(clk), .rst_n(rst_n), .bus(ifc.master));

  inst_fetch #(.PC_WIDTH(8), .INST_WIDTH(32), .RESET_PC(8'hF8), .PC_INC(8'd4))
    dut2 (.clk(clk), .rst_n(rst_n2), .bus(ifc2.master));

  always #5 clk = ~clk;

  function automatic logic [31:0] bram(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (ifc.imem_en)  ifc.imem_rdata  <= bram(ifc.imem_addr);
    if (ifc2.imem_en) ifc2.imem_rdata <= bram({24'h0, ifc2.imem_addr});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    q_pc.push_back(pc);
    q_inst.push_back(bram(pc));
  endtask

  task automatic push2(input logic [31:0] pc);
    q2_pc.push_back(pc);
    q2_inst.push_back(bram(pc));
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (ifc.out_valid && ifc.out_ready) begin
      if (q_pc.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_extra: got pc %h, expected no output", ifc.out_pc);
      end else begin
        e_pc   = q_pc.pop_front();
        e_inst = q_inst.pop_front();
        check("out_pc", ifc.out_pc, e_pc);
        check("out_inst", ifc.out_inst, e_inst);
      end
    end
    if (ifc2.out_valid && ifc2.out_ready) begin
      if (q2_pc.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out2_extra: got pc %h, expected no output", ifc2.out_pc);
      end else begin
        e2_pc   = q2_pc.pop_front();
        e2_inst = q2_inst.pop_front();
        check("wrap_out_pc", {24'h0, ifc2.out_pc}, e2_pc);
        check("wrap_out_inst", ifc2.out_inst, e2_inst);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    rst_n2 = 1'b1;
    ifc.work_ena = 1'b0;  ifc.pc_jump = 1'b0;  ifc.pc_target = '0;  ifc.out_ready = 1'b0;
    ifc2.work_ena = 1'b1; ifc2.pc_jump = 1'b0; ifc2.pc_target = '0; ifc2.out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    rst_n2 = 1'b0;
    #11;
    check("rst_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("rst_pc", ifc.out_pc, 32'h0);
    check("rst_inst", ifc.out_inst, 32'h0);
    check("rst_imem_en", {31'h0, ifc.imem_en}, 32'h0);

    // Streaming from reset, one issue per cycle.
    ifc.work_ena = 1'b1;
    ifc.out_ready = 1'b1;
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k <= 8) push(32'(4 * k));
      neg();
      check("stream_en", {31'h0, ifc.imem_en}, 32'h1);
      check("stream_addr", ifc.imem_addr, 32'(4 * k));
      next();
    end

    // work_ena low for three cycles, then restart from RESET_PC.
    ifc.work_ena = 1'b0;
    neg();
    check("idle_en", {31'h0, ifc.imem_en}, 32'h0);
    next();
    neg();
    check("idle_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("idle_en2", {31'h0, ifc.imem_en}, 32'h0);
    next();
    next();
    ifc.work_ena = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (r <= 3) push(32'(4 * r));
      neg();
      check("restart_en", {31'h0, ifc.imem_en}, 32'h1);
      check("restart_addr", ifc.imem_addr, 32'(4 * r));
      next();
    end

    // Redirect: in-flight 0x10 is dropped, target issues next cycle.
    ifc.pc_jump = 1'b1;
    ifc.pc_target = 32'h100;
    neg();
    check("jump_en", {31'h0, ifc.imem_en}, 32'h0);
    next();
    ifc.pc_jump = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j <= 2) push(32'h100 + 32'(4 * j));
      neg();
      check("jump_issue_en", {31'h0, ifc.imem_en}, 32'h1);
      check("jump_issue_addr", ifc.imem_addr, 32'h100 + 32'(4 * j));
      if (j < 2) check("jump_gap_valid", {31'h0, ifc.out_valid}, 32'h0);
      if (j < 4) next();
    end

    // Asynchronous reset between edges while output is valid.
    #2;
    rst_n = 1'b0;
    ifc.out_ready = 1'b0;
    #1;
    check("arst_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("arst_pc", ifc.out_pc, 32'h0);
    check("arst_inst", ifc.out_inst, 32'h0);
    check("arst_en", {31'h0, ifc.imem_en}, 32'h0);
    next();
    next();
    rst_n = 1'b1;

    // Backpressure from the start: exactly two issues, head held.
    for (int p = 0; p < 2; p++) begin
      push(32'(4 * p));
      neg();
      check("bp_issue_en", {31'h0, ifc.imem_en}, 32'h1);
      check("bp_issue_addr", ifc.imem_addr, 32'(4 * p));
      next();
    end
    for (int p = 0; p < 3; p++) begin
      neg();
      check("bp_stall_en", {31'h0, ifc.imem_en}, 32'h0);
      check("bp_hold_valid", {31'h0, ifc.out_valid}, 32'h1);
      check("bp_hold_pc", ifc.out_pc, 32'h0);
      check("bp_hold_inst", ifc.out_inst, bram(32'h0));
      next();
    end
    ifc.out_ready = 1'b1;
    for (int m = 0; m < 6; m++) begin
      if (m <= 3) push(32'd8 + 32'(4 * m));
      neg();
      check("bp_resume_en", {31'h0, ifc.imem_en}, 32'h1);
      check("bp_resume_addr", ifc.imem_addr, 32'd8 + 32'(4 * m));
      next();
    end
    ifc.out_ready = 1'b0;

    // 8-bit PC wraps from 0xFC to 0x00.
    next();
    rst_n2 = 1'b1;
    for (int w = 0; w < 6; w++) begin
      logic [7:0] a;
      a = 8'hF8 + 8'(4 * w);
      if (w <= 3) push2({24'h0, a});
      neg();
      if (w <= 3) begin
        check("wrap_en", {31'h0, ifc2.imem_en}, 32'h1);
        check("wrap_addr", {24'h0, ifc2.imem_addr}, {24'h0, a});
      end
      next();
    end
    ifc2.out_ready = 1'b0;

    repeat (3) next();
    check("scoreboard_left", 32'(q_pc.size()), 32'h0);
    check("scoreboard2_left", 32'(q2_pc.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
